// File: rtl/dcache_pkg.sv
// Shared constants, state encoding and line metadata for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned CACHE_ADDR_W    = 32;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned CACHE_LINE_W    = 256;
  localparam int unsigned WORDS_PER_LINE  = CACHE_LINE_W / WORD_W;
  localparam int unsigned CACHE_NUM_LINES = 32;

  localparam int unsigned OFFSET_W    = 5;
  localparam int unsigned WORD_SEL_LO = 2;
  localparam int unsigned WORD_SEL_W  = 3;
  localparam int unsigned INDEX_W     = 5;
  localparam int unsigned INDEX_LO    = OFFSET_W;
  localparam int unsigned TAG_W       = 22;
  localparam int unsigned TAG_LO      = OFFSET_W + INDEX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MISS,
    ST_WRITEBACK,
    ST_READMISS,
    ST_READMISSOK
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } line_meta_t;

endpackage

// File: rtl/dcache_sram.sv
// Line storage: combinational read by index, synchronous full-line fill or single-word store.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = CACHE_NUM_LINES,
  parameter int unsigned LINE_W    = CACHE_LINE_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    idx_i,
  output line_meta_t            meta_o,
  output logic [LINE_W-1:0]     data_o,
  input  logic                  line_we_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic [LINE_W-1:0]     line_i,
  input  logic                  word_we_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0]     word_i
);

  logic [NUM_LINES-1:0]                       valid_q;
  logic [NUM_LINES-1:0]                       dirty_q;
  logic [TAG_W-1:0]                           tag_q  [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0]      data_q [NUM_LINES];

  // Only the status bits are cleared; tag/data are masked by valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= line_i;
    end else if (word_we_i) begin
      data_q[idx_i][word_sel_i] <= word_i;
    end
  end

  assign meta_o = '{valid: valid_q[idx_i], dirty: dirty_q[idx_i], tag: tag_q[idx_i]};
  assign data_o = data_q[idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate direct-mapped cache controller: hit logic, miss FSM, memory handshake, pipeline stall.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W    = CACHE_ADDR_W,
  parameter int unsigned LINE_W    = CACHE_LINE_W,
  parameter int unsigned NUM_LINES = CACHE_NUM_LINES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_Addr_i,
  input  logic [WORD_W-1:0] p1_Data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_Data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_e                                state_q, state_d;
  line_meta_t                            meta;
  logic [LINE_W-1:0]                     rd_data;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] rd_words;
  logic [INDEX_W-1:0]                    idx;
  logic [TAG_W-1:0]                      req_tag;
  logic [WORD_SEL_W-1:0]                 word_sel;
  logic                                  req, hit, line_we, word_we;
  logic                                  unused_addr_bits;

  assign idx              = p1_Addr_i[INDEX_LO +: INDEX_W];
  assign req_tag          = p1_Addr_i[TAG_LO +: TAG_W];
  assign word_sel         = p1_Addr_i[WORD_SEL_LO +: WORD_SEL_W];
  assign unused_addr_bits = ^p1_Addr_i[1:0];

  assign req      = p1_MemRead_i | p1_MemWrite_i;
  assign hit      = req & meta.valid & (meta.tag == req_tag);
  assign rd_words = rd_data;

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (idx),
    .meta_o     (meta),
    .data_o     (rd_data),
    .line_we_i  (line_we),
    .tag_i      (req_tag),
    .line_i     (mem_data_i),
    .word_we_i  (word_we),
    .word_sel_i (word_sel),
    .word_i     (p1_Data_i)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, Moore memory-side decode, SRAM write strobes and stall.
  always_comb begin
    state_d      = state_q;
    p1_stall_o   = 1'b1;
    p1_Data_o    = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        p1_stall_o = req & ~hit;
        word_we    = hit & p1_MemWrite_i;
        if (hit) p1_Data_o = rd_words[word_sel];
        if (req & ~hit) state_d = ST_MISS;
      end
      ST_MISS: begin
        state_d = (meta.valid & meta.dirty) ? ST_WRITEBACK : ST_READMISS;
      end
      ST_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = ADDR_W'({meta.tag, idx, OFFSET_W'(0)});
        mem_data_o   = rd_data;
        if (mem_ack_i) state_d = ST_READMISS;
      end
      ST_READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = ADDR_W'({req_tag, idx, OFFSET_W'(0)});
        if (mem_ack_i) begin
          line_we = 1'b1;
          state_d = ST_READMISSOK;
        end
      end
      ST_READMISSOK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency line memory responder.
module tb_dcache_controller;

  localparam int MEM_LAT = 10;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_Addr_i, p1_Data_i, p1_Data_o, mem_addr_o;
  logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;

  int checks = 0;
  int errors = 0;

  logic [255:0] mem_model [int unsigned];
  logic [31:0]  req_addr [16];
  logic         req_wr   [16];
  logic [255:0] req_data [16];
  int           req_n = 0;
  int           inject_req = 0;
  int           inject_done = 0;

  dcache_controller dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_Addr_i     (p1_Addr_i),
    .p1_Data_i     (p1_Data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_Data_o     (p1_Data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] pattern_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h1000_0000 + a + 32'(i);
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return pattern_line(a);
  endfunction

  // Memory: ack in the MEM_LAT-th consecutive enabled cycle of each transaction.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (inject_done != inject_req) begin
        inject_done = inject_req;
        mem_ack_i   = 1'b1;
        mem_data_i  = '1;
        cnt         = 0;
      end else if (mem_enable_o) begin
        cnt++;
        if (cnt == MEM_LAT) begin
          cnt       = 0;
          mem_ack_i = 1'b1;
          if (req_n < 16) begin
            req_addr[req_n] = mem_addr_o;
            req_wr[req_n]   = mem_write_o;
            req_data[req_n] = mem_data_o;
            req_n++;
          end
          if (mem_write_o) mem_model[mem_addr_o] = mem_data_o;
          else             mem_data_i = line_of(mem_addr_o);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Present one CPU access, hold it through the stall, return stall count and load data.
  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wdata, output int stalls, output logic [31:0] rdata);
    @(negedge clk_i);
    p1_Addr_i = addr; p1_MemRead_i = rd; p1_MemWrite_i = wr; p1_Data_i = wdata;
    #1;
    stalls = 0;
    while (p1_stall_o && stalls < 1000) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    rdata = p1_Data_o;
    @(negedge clk_i);
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  task automatic test_reset();
    p1_Addr_i = '0; p1_Data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({p1_stall_o, mem_enable_o, mem_write_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {p1_stall_o, mem_enable_o, mem_write_o});
    end
    checks++;
    if ({p1_Data_o, mem_addr_o} !== 64'h0 || mem_data_o !== 256'h0) begin
      errors++; $display("FAIL reset_data: data=%h addr=%h expected 0", p1_Data_o, mem_addr_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_cold_read_miss();
    int st; logic [31:0] d; int base;
    base = req_n;
    access(32'h0000_0404, 1'b1, 1'b0, 32'h0, st, d);
    checks++;
    if (st !== MEM_LAT + 3) begin errors++; $display("FAIL cold_stall: got %0d expected %0d", st, MEM_LAT + 3); end
    checks++;
    if (d !== 32'h1000_0401) begin errors++; $display("FAIL cold_data: got %h expected 10000401", d); end
    checks++;
    if (req_n - base !== 1) begin errors++; $display("FAIL cold_req_count: got %0d expected 1", req_n - base); end
    else begin
      checks++;
      if ({req_wr[base], req_addr[base]} !== {1'b0, 32'h0000_0400}) begin
        errors++; $display("FAIL cold_req: got wr=%b addr=%h expected wr=0 addr=00000400", req_wr[base], req_addr[base]);
      end
    end
  endtask

  task automatic test_write_hit_load();
    int st; logic [31:0] d; int base;
    base = req_n;
    access(32'h0000_0404, 1'b0, 1'b1, 32'hDEAD_BEEF, st, d);
    checks++;
    if (st !== 0) begin errors++; $display("FAIL whit_stall: got %0d expected 0", st); end
    access(32'h0000_0404, 1'b1, 1'b0, 32'h0, st, d);
    checks++;
    if (st !== 0) begin errors++; $display("FAIL whit_load_stall: got %0d expected 0", st); end
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL whit_load_data: got %h expected deadbeef", d); end
    checks++;
    if (req_n !== base) begin errors++; $display("FAIL whit_no_mem: got %0d requests expected 0", req_n - base); end
  endtask

  task automatic test_dirty_eviction();
    int st; logic [31:0] d; int base; logic [255:0] exp_wb;
    base = req_n;
    exp_wb = pattern_line(32'h0000_0400);
    exp_wb[32 +: 32] = 32'hDEAD_BEEF;
    access(32'h0000_0804, 1'b1, 1'b0, 32'h0, st, d);
    checks++;
    if (st !== 2 * MEM_LAT + 3) begin errors++; $display("FAIL evict_stall: got %0d expected %0d", st, 2 * MEM_LAT + 3); end
    checks++;
    if (d !== 32'h1000_0801) begin errors++; $display("FAIL evict_data: got %h expected 10000801", d); end
    checks++;
    if (req_n - base !== 2) begin errors++; $display("FAIL evict_req_count: got %0d expected 2", req_n - base); end
    else begin
      checks++;
      if ({req_wr[base], req_addr[base]} !== {1'b1, 32'h0000_0400} || req_data[base] !== exp_wb) begin
        errors++; $display("FAIL evict_wb: got wr=%b addr=%h data=%h expected wr=1 addr=00000400 data=%h",
                           req_wr[base], req_addr[base], req_data[base], exp_wb);
      end
      checks++;
      if ({req_wr[base+1], req_addr[base+1]} !== {1'b0, 32'h0000_0800}) begin
        errors++; $display("FAIL evict_fill: got wr=%b addr=%h expected wr=0 addr=00000800", req_wr[base+1], req_addr[base+1]);
      end
    end
  endtask

  task automatic test_write_miss_allocate();
    int st; logic [31:0] d, exp; int base; logic [255:0] exp_wb;
    access(32'h0000_0048, 1'b0, 1'b1, 32'h1234_5678, st, d);
    checks++;
    if (st !== MEM_LAT + 3) begin errors++; $display("FAIL wmiss_stall: got %0d expected %0d", st, MEM_LAT + 3); end
    for (int i = 0; i < 8; i++) begin
      exp = (i == 2) ? 32'h1234_5678 : 32'h1000_0040 + 32'(i);
      access(32'h0000_0040 + 32'(4 * i), 1'b1, 1'b0, 32'h0, st, d);
      checks++;
      if (st !== 0 || d !== exp) begin
        errors++; $display("FAIL wmiss_word%0d: got stall=%0d data=%h expected stall=0 data=%h", i, st, d, exp);
      end
    end
    // Evicting the allocated line must write it back, proving it was marked dirty.
    base = req_n;
    exp_wb = pattern_line(32'h0000_0040);
    exp_wb[64 +: 32] = 32'h1234_5678;
    access(32'h0000_0448, 1'b1, 1'b0, 32'h0, st, d);
    checks++;
    if (st !== 2 * MEM_LAT + 3 || d !== 32'h1000_0442) begin
      errors++; $display("FAIL wmiss_evict: got stall=%0d data=%h expected stall=%0d data=10000442", st, d, 2 * MEM_LAT + 3);
    end
    checks++;
    if (req_n - base !== 2 || req_addr[base] !== 32'h0000_0040 || req_data[base] !== exp_wb) begin
      errors++; $display("FAIL wmiss_wb: got n=%0d addr=%h data=%h expected n=2 addr=00000040 data=%h",
                         req_n - base, req_addr[base], req_data[base], exp_wb);
    end
  endtask

  task automatic test_reset_mid_readmiss();
    int st; logic [31:0] d; int base;
    @(negedge clk_i);
    p1_Addr_i = 32'h0000_0C20; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #2;
    checks++;
    if ({mem_enable_o, mem_write_o, mem_addr_o} !== {2'b10, 32'h0000_0C20}) begin
      errors++; $display("FAIL rst_pre: got en=%b wr=%b addr=%h expected en=1 wr=0 addr=00000c20", mem_enable_o, mem_write_o, mem_addr_o);
    end
    base = req_n;
    rst_i = 1'b0; p1_MemRead_i = 1'b0;
    #1;
    checks++;
    if ({p1_stall_o, mem_enable_o, mem_write_o, p1_Data_o, mem_addr_o} !== 67'h0 || mem_data_o !== 256'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got stall=%b en=%b wr=%b addr=%h expected all 0", p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    inject_req++;
    repeat (3) @(negedge clk_i);
    access(32'h0000_0C20, 1'b1, 1'b0, 32'h0, st, d);
    checks++;
    if (st !== MEM_LAT + 3 || d !== 32'h1000_0C20) begin
      errors++; $display("FAIL rst_late_ack: got stall=%0d data=%h expected stall=%0d data=10000c20", st, d, MEM_LAT + 3);
    end
    checks++;
    if (req_n - base !== 1) begin errors++; $display("FAIL rst_req_count: got %0d expected 1", req_n - base); end
    access(32'h0000_0804, 1'b1, 1'b0, 32'h0, st, d);
    checks++;
    if (st !== MEM_LAT + 3 || d !== 32'h1000_0801) begin
      errors++; $display("FAIL rst_cleared_valid: got stall=%0d data=%h expected stall=%0d data=10000801", st, d, MEM_LAT + 3);
    end
  endtask

  task automatic test_read_write_simultaneous();
    int st; logic [31:0] d;
    access(32'h0000_0808, 1'b1, 1'b1, 32'hCAFE_F00D, st, d);
    checks++;
    if (st !== 0) begin errors++; $display("FAIL rw_stall: got %0d expected 0", st); end
    access(32'h0000_0808, 1'b1, 1'b0, 32'h0, st, d);
    checks++;
    if (st !== 0 || d !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rw_readback: got stall=%0d data=%h expected stall=0 data=cafef00d", st, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr_v [4] = '{32'h0000_0800, 32'h0000_0C24, 32'h0000_080C, 32'h0000_0C24};
    logic        wr_v   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp_v  [4] = '{32'h1000_0800, 32'h0000_0000, 32'h1000_0803, 32'h5555_AAAA};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      p1_Addr_i = addr_v[i]; p1_MemRead_i = ~wr_v[i]; p1_MemWrite_i = wr_v[i]; p1_Data_i = 32'h5555_AAAA;
      #1;
      checks++;
      if (p1_stall_o !== 1'b0 || (!wr_v[i] && p1_Data_o !== exp_v[i])) begin
        errors++; $display("FAIL b2b_%0d: got stall=%b data=%h expected stall=0 data=%h", i, p1_stall_o, p1_Data_o, exp_v[i]);
      end
    end
    @(negedge clk_i);
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_read_miss();
    test_write_hit_load();
    test_dirty_eviction();
    test_write_miss_allocate();
    test_reset_mid_readmiss();
    test_read_write_simultaneous();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
